alu_rr_arbiter: RTL and testbench



---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_rr_arbiter_if.sv | 44 ++++
 rtl/alu_32bit.sv | 60 ++++++
 rtl/alu_rr_grant.sv | 44 ++++
 rtl/alu_rr_arbiter.sv | 119 +++++++++++
 tb/tb_alu_rr_arbiter.sv | 240 ++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU datapath: operand width, ALU select codes
// and the response-slot state encoding.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] ALU_TFR_A = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0010;
    localparam logic [3:0] ALU_DEC   = 4'b0011;
    localparam logic [3:0] ALU_AND   = 4'b0100;
    localparam logic [3:0] ALU_OR    = 4'b0101;
    localparam logic [3:0] ALU_XOR   = 4'b0110;
    localparam logic [3:0] ALU_NOT   = 4'b0111;
    localparam logic [3:0] ALU_SHR   = 4'b1000;
    localparam logic [3:0] ALU_SHL   = 4'b1100;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Request/response bundle of the shared-ALU arbiter. Signal names carry the
// direction as seen from the arbiter.
interface alu_rr_arbiter_if #(parameter int CNT_W = 16) ();
    import alu_pkg::*;

    logic              req0_valid_i;
    logic              req0_ready_o;
    logic [DATA_W-1:0] req0_a_i;
    logic [DATA_W-1:0] req0_b_i;
    logic              req0_cin_i;
    logic [3:0]        req0_sel_i;

    logic              req1_valid_i;
    logic              req1_ready_o;
    logic [DATA_W-1:0] req1_a_i;
    logic [DATA_W-1:0] req1_b_i;
    logic              req1_cin_i;
    logic [3:0]        req1_sel_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_f_o;
    logic              rsp_cout_o;
    logic              rsp_zero_o;
    logic              rsp_id_o;
    logic [CNT_W-1:0]  op_count_o;

    modport slave (
        input  req0_valid_i, req0_a_i, req0_b_i, req0_cin_i, req0_sel_i,
        input  req1_valid_i, req1_a_i, req1_b_i, req1_cin_i, req1_sel_i,
        input  rsp_ready_i,
        output req0_ready_o, req1_ready_o,
        output rsp_valid_o, rsp_f_o, rsp_cout_o, rsp_zero_o, rsp_id_o, op_count_o
    );

    modport master (
        output req0_valid_i, req0_a_i, req0_b_i, req0_cin_i, req0_sel_i,
        output req1_valid_i, req1_a_i, req1_b_i, req1_cin_i, req1_sel_i,
        output rsp_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp_valid_o, rsp_f_o, rsp_cout_o, rsp_zero_o, rsp_id_o, op_count_o
    );

endinterface

// File: rtl/alu_32bit.sv
// Combinational 32-bit ALU. Shifts move by one bit and report the bit shifted
// out on cout; logic operations clear cout.
module alu_32bit
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              cin_i,
    input  logic [3:0]        sel_i,
    output logic [DATA_W-1:0] f_o,
    output logic              cout_o
);

    logic [DATA_W:0] sum_s;
    logic [DATA_W:0] cin_ext_s;

    assign cin_ext_s = {{DATA_W{1'b0}}, cin_i};

    // Operation decode.
    always_comb begin
        sum_s  = {(DATA_W+1){1'b0}};
        f_o    = {DATA_W{1'b0}};
        cout_o = 1'b0;
        casez (sel_i)
            4'b0000: begin
                sum_s  = {1'b0, a_i} + cin_ext_s;
                {cout_o, f_o} = sum_s;
            end
            4'b0001: begin
                sum_s  = {1'b0, a_i} + {1'b0, b_i} + cin_ext_s;
                {cout_o, f_o} = sum_s;
            end
            4'b0010: begin
                sum_s  = {1'b0, a_i} + {1'b0, ~b_i} + cin_ext_s;
                {cout_o, f_o} = sum_s;
            end
            4'b0011: begin
                sum_s  = {1'b0, a_i} + {1'b0, {DATA_W{1'b1}}} + cin_ext_s;
                {cout_o, f_o} = sum_s;
            end
            4'b0100: f_o = a_i & b_i;
            4'b0101: f_o = a_i | b_i;
            4'b0110: f_o = a_i ^ b_i;
            4'b0111: f_o = ~a_i;
            4'b10??: begin
                f_o    = {1'b0, a_i[DATA_W-1:1]};
                cout_o = a_i[0];
            end
            4'b11??: begin
                f_o    = {a_i[DATA_W-2:0], 1'b0};
                cout_o = a_i[DATA_W-1];
            end
            default: begin
                f_o    = {DATA_W{1'b0}};
                cout_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_rr_grant.sv
// Two-way round-robin grant. On contention the channel that did not win the
// previous accepted transfer is preferred.
module alu_rr_grant (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic accept_i,
    output logic gnt_valid_o,
    output logic gnt_id_o
);

    logic last_q;
    logic last_d;

    // Grant selection and pointer update.
    always_comb begin
        gnt_valid_o = valid0_i | valid1_i;
        gnt_id_o    = 1'b0;
        last_d      = last_q;
        if (valid0_i && valid1_i) begin
            gnt_id_o = ~last_q;
        end else if (valid1_i) begin
            gnt_id_o = 1'b1;
        end else begin
            gnt_id_o = 1'b0;
        end
        if (accept_i) begin
            last_d = gnt_id_o;
        end else begin
            last_d = last_q;
        end
    end

    // Reset to 1 so channel 0 wins the first contention.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one alu_32bit between two requesters and registers each result into
// a single-entry tagged response slot.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    alu_rr_arbiter_if.slave bus
);

    slot_state_e       state_q, state_d;
    logic              gnt_valid_s, gnt_id_s;
    logic              slot_free_s, accept_s, consume_s;
    logic              ready0_s, ready1_s;
    logic [DATA_W-1:0] alu_a_s, alu_b_s, alu_f_s;
    logic              alu_cin_s, alu_cout_s;
    logic [3:0]        alu_sel_s;
    logic [DATA_W-1:0] f_q;
    logic              cout_q, zero_q, id_q;
    logic [CNT_W-1:0]  count_q;

    alu_rr_grant u_grant (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid0_i    (bus.req0_valid_i),
        .valid1_i    (bus.req1_valid_i),
        .accept_i    (accept_s),
        .gnt_valid_o (gnt_valid_s),
        .gnt_id_o    (gnt_id_s)
    );

    assign slot_free_s = (state_q == ST_EMPTY) | bus.rsp_ready_i;
    assign ready0_s    = ~rst_i & slot_free_s & gnt_valid_s & ~gnt_id_s & bus.req0_valid_i;
    assign ready1_s    = ~rst_i & slot_free_s & gnt_valid_s &  gnt_id_s & bus.req1_valid_i;
    assign accept_s    = ready0_s | ready1_s;
    assign consume_s   = (state_q == ST_FULL) & bus.rsp_ready_i;

    // Operand mux; channel 0 is presented when nothing is granted.
    always_comb begin
        if (gnt_id_s) begin
            alu_a_s   = bus.req1_a_i;
            alu_b_s   = bus.req1_b_i;
            alu_cin_s = bus.req1_cin_i;
            alu_sel_s = bus.req1_sel_i;
        end else begin
            alu_a_s   = bus.req0_a_i;
            alu_b_s   = bus.req0_b_i;
            alu_cin_s = bus.req0_cin_i;
            alu_sel_s = bus.req0_sel_i;
        end
    end

    alu_32bit u_alu (
        .a_i    (alu_a_s),
        .b_i    (alu_b_s),
        .cin_i  (alu_cin_s),
        .sel_i  (alu_sel_s),
        .f_o    (alu_f_s),
        .cout_o (alu_cout_s)
    );

    // Slot next-state: a consume with a simultaneous accept keeps the slot full.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) state_d = ST_FULL;
                else          state_d = ST_EMPTY;
            end
            ST_FULL: begin
                if (bus.rsp_ready_i && !accept_s) state_d = ST_EMPTY;
                else                              state_d = ST_FULL;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State, slot contents and saturating consume counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            f_q     <= {DATA_W{1'b0}};
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            id_q    <= 1'b0;
            count_q <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            if (accept_s) begin
                f_q    <= alu_f_s;
                cout_q <= alu_cout_s;
                zero_q <= (alu_f_s == {DATA_W{1'b0}});
                id_q   <= gnt_id_s;
            end else begin
                f_q    <= f_q;
                cout_q <= cout_q;
                zero_q <= zero_q;
                id_q   <= id_q;
            end
            if (consume_s && (count_q != {CNT_W{1'b1}})) begin
                count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                count_q <= count_q;
            end
        end
    end

    assign bus.req0_ready_o = ready0_s;
    assign bus.req1_ready_o = ready1_s;
    assign bus.rsp_valid_o  = (state_q == ST_FULL);
    assign bus.rsp_f_o      = f_q;
    assign bus.rsp_cout_o   = cout_q;
    assign bus.rsp_zero_o   = zero_q;
    assign bus.rsp_id_o     = id_q;
    assign bus.op_count_o   = count_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level reference model.
module tb_alu_rr_arbiter;
    import alu_pkg::*;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_rr_arbiter_if #(.CNT_W(CW)) bus ();
    alu_rr_arbiter #(.CNT_W(CW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    typedef struct packed {
        logic [31:0] f;
        logic        cout;
        logic        zero;
        logic        id;
    } rsp_t;

    rsp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          m_full   = 1'b0;
    bit          m_last   = 1'b1;
    int          m_count  = 0;
    bit          acc[2];
    logic        c_v[2];
    logic [31:0] c_a[2], c_b[2];
    logic        c_cin[2];
    logic [3:0]  c_sel[2];

    function automatic rsp_t ref_alu(logic [31:0] a, logic [31:0] b, logic cin,
                                     logic [3:0] sel, logic id);
        rsp_t r;
        longint unsigned s;
        s = 0;
        r.cout = 1'b0;
        if (sel[3]) begin
            if (sel[2]) begin r.f = a << 1; r.cout = a[31]; end
            else        begin r.f = a >> 1; r.cout = a[0];  end
        end else begin
            case (sel[2:0])
                3'd0: s = longint'(a) + cin;
                3'd1: s = longint'(a) + longint'(b) + cin;
                3'd2: s = longint'(a) + (64'h0000_0000_FFFF_FFFF - longint'(b)) + cin;
                3'd3: s = longint'(a) + 64'h0000_0000_FFFF_FFFF + cin;
                3'd4: s = longint'(a & b);
                3'd5: s = longint'(a | b);
                3'd6: s = longint'(a ^ b);
                default: s = longint'(~a);
            endcase
            r.f = s[31:0];
            r.cout = (sel[2] == 1'b0) ? s[32] : 1'b0;
        end
        r.zero = (r.f == 32'd0);
        r.id = id;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int ch, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic cin, input logic [3:0] sel);
        c_v[ch] = v; c_a[ch] = a; c_b[ch] = b; c_cin[ch] = cin; c_sel[ch] = sel;
    endtask

    // One cycle, called at a falling edge: check state, drive, predict, advance model.
    task automatic step(input logic rst_v, input logic rdy);
        bit p[2];
        bit free;
        chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(m_full));
        chk("op_count", 32'(bus.op_count_o), 32'(m_count));
        rst = rst_v;
        bus.rsp_ready_i  = rdy;
        bus.req0_valid_i = c_v[0]; bus.req0_a_i = c_a[0]; bus.req0_b_i = c_b[0];
        bus.req0_cin_i   = c_cin[0]; bus.req0_sel_i = c_sel[0];
        bus.req1_valid_i = c_v[1]; bus.req1_a_i = c_a[1]; bus.req1_b_i = c_b[1];
        bus.req1_cin_i   = c_cin[1]; bus.req1_sel_i = c_sel[1];
        p[0] = 1'b0; p[1] = 1'b0;
        free = !m_full || rdy;
        if (!rst_v && free) begin
            if (c_v[0] && c_v[1]) p[m_last ? 0 : 1] = 1'b1;
            else if (c_v[0])      p[0] = 1'b1;
            else if (c_v[1])      p[1] = 1'b1;
        end
        if (rst_v) begin
            m_full = 1'b0; m_last = 1'b1; m_count = 0;
            exp_q.delete();
        end else begin
            if (m_full && rdy && m_count < CMAX) m_count++;
            for (int ch = 0; ch < 2; ch++) begin
                if (p[ch]) begin
                    exp_q.push_back(ref_alu(c_a[ch], c_b[ch], c_cin[ch], c_sel[ch], ch[0]));
                    m_last = ch[0];
                end
            end
            m_full = p[0] || p[1] || (m_full && !rdy);
        end
        acc = p;
        #1;
        chk("req0_ready", 32'(bus.req0_ready_o), 32'(p[0]));
        chk("req1_ready", 32'(bus.req1_ready_o), 32'(p[1]));
        @(negedge clk);
    endtask

    // Response monitor: compares the held slot against the scoreboard head.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.rsp_valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got valid response f=%h expected none", bus.rsp_f_o);
                end else begin
                    e = exp_q[0];
                    chk("rsp_f", bus.rsp_f_o, e.f);
                    chk("rsp_cout", 32'(bus.rsp_cout_o), 32'(e.cout));
                    chk("rsp_zero", 32'(bus.rsp_zero_o), 32'(e.zero));
                    chk("rsp_id", 32'(bus.rsp_id_o), 32'(e.id));
                    if (bus.rsp_ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // Single add on channel 0.
        set_req(0, 1'b1, 32'hA5A5F0F0, 32'h0F0F5A5A, 1'b0, ALU_ADD);
        step(1'b0, 1'b1);
        chk("t1_f", bus.rsp_f_o, 32'hB4B54B4A);
        chk("t1_cout", 32'(bus.rsp_cout_o), 32'd0);
        chk("t1_id", 32'(bus.rsp_id_o), 32'd0);
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        step(1'b0, 1'b1);
        chk("t1_count", 32'(bus.op_count_o), 32'd1);

        // Contention alternates; channel 0 won last so channel 1 goes first.
        set_req(0, 1'b1, 32'hA5A5F0F0, 32'h0F0F5A5A, 1'b0, ALU_AND);
        set_req(1, 1'b1, 32'hA5A5F0F0, 32'h0F0F5A5A, 1'b0, ALU_XOR);
        step(1'b0, 1'b1);
        chk("rr_first", bus.rsp_f_o, 32'hAAAAAAAA);
        step(1'b0, 1'b1);
        chk("rr_second", bus.rsp_f_o, 32'h05055050);
        repeat (4) step(1'b0, 1'b1);
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        step(1'b0, 1'b1);

        // Backpressure holds the slot while channel 1 waits.
        set_req(1, 1'b1, 32'hA5A5F0F0, 32'd0, 1'b0, ALU_DEC);
        step(1'b0, 1'b0);
        set_req(1, 1'b1, 32'h00000001, 32'h00000001, 1'b0, ALU_ADD);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            chk("bp_hold", bus.rsp_f_o, 32'hA5A5F0EF);
        end
        step(1'b0, 1'b1);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        // Zero flag, then shift right.
        set_req(0, 1'b1, 32'h12345678, 32'h12345678, 1'b1, ALU_SUB);
        step(1'b0, 1'b1);
        chk("zero_f", bus.rsp_f_o, 32'h00000000);
        chk("zero_flag", 32'(bus.rsp_zero_o), 32'd1);
        chk("zero_cout", 32'(bus.rsp_cout_o), 32'd1);
        set_req(0, 1'b1, 32'hA5A5F0F0, 32'd0, 1'b0, ALU_SHR);
        step(1'b0, 1'b1);
        chk("shr_f", bus.rsp_f_o, 32'h52D2F878);
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        step(1'b0, 1'b1);

        // Reset while the slot is full and stalled.
        set_req(1, 1'b1, 32'h11111111, 32'h22222222, 1'b0, ALU_OR);
        step(1'b0, 1'b0);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("rst_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst_count", 32'(bus.op_count_o), 32'd0);
        set_req(0, 1'b1, 32'h0000FFFF, 32'h00000001, 1'b1, ALU_ADD);
        set_req(1, 1'b1, 32'hFFFF0000, 32'h00000001, 1'b0, ALU_NOT);
        step(1'b0, 1'b1);
        chk("rst_grant", 32'(bus.rsp_id_o), 32'd0);
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        step(1'b0, 1'b1);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        step(1'b0, 1'b1);

        // Counter saturation.
        for (int i = 0; i < 20; i++) begin
            set_req(0, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            step(1'b0, 1'b1);
        end
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        step(1'b0, 1'b1);
        chk("sat_count", 32'(bus.op_count_o), 32'h0000000F);

        // Random traffic; an unaccepted request is held stable.
        for (int i = 0; i < 600; i++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (!(c_v[ch] && !acc[ch])) begin
                    set_req(ch, 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
                end
            end
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) < 7));
        end

        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
